// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: register address
// width, controller state encoding and the source/dest match rule.
package hazard_ctrl_pkg;

   localparam int unsigned REG_FILE_ADDR_LEN = 5;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hz_state_t;

   // Register 0 is hardwired, so it never creates a dependency.
   function automatic logic src_match(
      input logic [REG_FILE_ADDR_LEN-1:0] src,
      input logic [REG_FILE_ADDR_LEN-1:0] dest,
      input logic                         used
   );
      return used && (dest != '0) && (src == dest);
   endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module hazard_ctrl_sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: per-stage enables/flushes from RAW hazards,
// taken branches and multi-cycle data-memory freezes, plus perf counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter bit          FWD_EN  = 1'b1,
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [REG_FILE_ADDR_LEN-1:0] id_src1,
   input  logic [REG_FILE_ADDR_LEN-1:0] id_src2,
   input  logic                         id_two_src,
   input  logic [REG_FILE_ADDR_LEN-1:0] ex_dest,
   input  logic                         ex_wb_en,
   input  logic                         ex_mem_r_en,
   input  logic [REG_FILE_ADDR_LEN-1:0] mem_dest,
   input  logic                         mem_wb_en,
   input  logic                         br_taken,
   input  logic                         dmem_req,
   input  logic                         dmem_ack,
   output logic                         pc_en,
   output logic                         ifid_en,
   output logic                         ifid_flush,
   output logic                         idex_en,
   output logic                         idex_flush,
   output logic                         exmem_en,
   output logic                         mem_timeout,
   output logic [CNT_W-1:0]             stall_cnt,
   output logic [CNT_W-1:0]             flush_cnt
);

   localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

   hz_state_t         state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              tmo_q, tmo_d;
   logic              freeze, hazard, match_ex, match_mem;
   logic              stall_inc, flush_inc;

   assign match_ex  = src_match(id_src1, ex_dest, 1'b1)
                    | src_match(id_src2, ex_dest, id_two_src);
   assign match_mem = src_match(id_src1, mem_dest, 1'b1)
                    | src_match(id_src2, mem_dest, id_two_src);

   always_comb begin
      if (FWD_EN) begin
         hazard = ex_wb_en & ex_mem_r_en & match_ex;
      end else begin
         hazard = (ex_wb_en & match_ex) | (mem_wb_en & match_mem);
      end
   end

   assign freeze = (state_q == RUN) ? (dmem_req & ~dmem_ack) : ~dmem_ack;

   // wait_d is the MEM_WAIT cycle index; the timeout flag is raised on the
   // TIMEOUT-th consecutive frozen cycle, counting the RUN cycle that entered.
   always_comb begin
      wait_d = '0;
      if (state_q == MEM_WAIT) begin
         wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
      end
      tmo_d = tmo_q | (freeze & (wait_d == WAIT_MAX));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         wait_q  <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:      if (dmem_req && !dmem_ack) state_d = MEM_WAIT;
         MEM_WAIT: if (dmem_ack)              state_d = RUN;
         default:  state_d = RUN;
      endcase
   end

   always_comb begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b0;
      idex_en    = 1'b0;
      idex_flush = 1'b0;
      exmem_en   = 1'b0;
      if (!rst && !freeze) begin
         if (br_taken) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
         end else if (hazard) begin
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
         end else begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
         end
      end
   end

   assign stall_inc   = freeze | (~br_taken & hazard);
   assign flush_inc   = ~freeze & br_taken;
   assign mem_timeout = tmo_q;

   hazard_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i (clk),
      .clr_i (rst),
      .inc_i (stall_inc),
      .cnt_o (stall_cnt)
   );

   hazard_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i (clk),
      .clr_i (rst),
      .inc_i (flush_inc),
      .cnt_o (flush_cnt)
   );

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Generates per-stage enable (stall) and flush controls for PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Detects RAW data hazards against the ID/EX and EX/MEM stages, applies branch-taken flushes, and freezes the whole pipe during multi-cycle data-memory accesses.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout error.

Parameters:
- FWD_EN, 1, 1 = forwarding unit present (stall only on load-use); 0 = stall on any RAW against EX or MEM stage.
- TIMEOUT, 64, max cycles in MEM_WAIT before mem_timeout sets.
- CNT_W, 16, width of performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- id_src1  in  REG_FILE_ADDR_LEN  ID-stage source register 1
- id_src2  in  REG_FILE_ADDR_LEN  ID-stage source register 2
- id_two_src  in  1  ID instruction reads src2
- ex_dest  in  REG_FILE_ADDR_LEN  ID/EX dest
- ex_wb_en  in  1  ID/EX WB_EN
- ex_mem_r_en  in  1  ID/EX MEM_R_EN (load in EX)
- mem_dest  in  REG_FILE_ADDR_LEN  EX/MEM dest
- mem_wb_en  in  1  EX/MEM WB_EN
- br_taken  in  1  branch resolved taken in EX
- dmem_req  in  1  MEM stage issuing data-memory access
- dmem_ack  in  1  data memory completes access
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID clear to bubble
- idex_en  out  1  ID/EX load enable
- idex_flush  out  1  ID/EX clear to bubble
- exmem_en  out  1  EX/MEM load enable
- mem_timeout  out  1  sticky error
- stall_cnt  out  CNT_W  data-hazard + memory stall cycles
- flush_cnt  out  CNT_W  branch flush events

Behaviour:
- Reset (rst=1 at posedge): state=RUN, stall_cnt=0, flush_cnt=0, wait_cnt=0, mem_timeout=0. While rst is high, all enables are 0 and all flushes are 0.
- States: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when dmem_req=1 and dmem_ack=0.
  - MEM_WAIT -> RUN on the cycle dmem_ack=1.
  - dmem_req with dmem_ack in the same cycle stays in RUN with no freeze.
- Control outputs are combinational from state and inputs (zero latency). Priority, highest first:
  1. Freeze: (RUN and dmem_req and !dmem_ack) or (MEM_WAIT and !dmem_ack). All enables 0, all flushes 0. br_taken and hazards are ignored; they remain stable because EX/MEM are held.
  2. Branch: br_taken=1. pc_en=1, ifid_flush=1, idex_flush=1, ifid_en=1, idex_en=1, exmem_en=1. Branch overrides data-hazard stall because the ID instruction is wrong-path.
  3. Data hazard: pc_en=0, ifid_en=0, idex_flush=1 (bubble), idex_en=1, exmem_en=1.
  4. Otherwise: all enables 1, all flushes 0.
- Hazard match: a source register matches a dest only if the dest is nonzero and the source is actually used (src2 only when id_two_src=1). Register 0 never hazards.
  - FWD_EN=1: hazard = ex_wb_en and ex_mem_r_en and match(ex_dest). This gives exactly one bubble per load-use.
  - FWD_EN=0: hazard = (ex_wb_en and match(ex_dest)) or (mem_wb_en and match(mem_dest)).
- wait_cnt: cleared in RUN, increments each MEM_WAIT cycle.
  - mem_timeout sets when wait_cnt reaches TIMEOUT-1 while still waiting.
  - mem_timeout stays set until rst. No automatic recovery; the freeze continues.
- stall_cnt increments on every cycle with freeze or data-hazard stall. flush_cnt increments on every branch-flush cycle. Both saturate at all-ones.
- rst mid-MEM_WAIT: returns to RUN on the next edge regardless of dmem_ack.

Decomposition:
- Shared package `defines`: REG_FILE_ADDR_LEN; new typedef hz_state_t {RUN, MEM_WAIT}.
- One natural sub-module: sat_counter (parameterised width, inc, clr), instantiated for stall_cnt and flush_cnt.

Test Plan:
- Load-use: FWD_EN=1, ex_mem_r_en=1, ex_wb_en=1, ex_dest=5, id_src1=5 -> pc_en=0, ifid_en=0, idex_flush=1 for one cycle; stall_cnt=1.
- Zero register: ex_dest=0, id_src1=0, load in EX -> no stall, all enables 1.
- Unused src2: ex_dest=7, id_src2=7, id_two_src=0 -> no stall. Same with id_two_src=1 -> stall.
- Branch vs hazard: br_taken=1 with an active load-use hazard -> ifid_flush=1, idex_flush=1, pc_en=1; flush_cnt=1, stall_cnt unchanged.
- Memory wait: dmem_req=1, dmem_ack=0 for 3 cycles, then ack -> all enables 0 for 3 cycles, RUN with enables 1 on the ack cycle; stall_cnt=3. With TIMEOUT=4 and no ack for 4 cycles -> mem_timeout=1, held until rst.
- Reset mid-wait: rst=1 during MEM_WAIT -> next cycle counters 0, mem_timeout 0, state RUN.
